// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width for serial_adder.
package serial_adder_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_full_add.sv
// full_add: one-bit full adder built from two half-adder stages.
module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_s1, w_c1, w_c2;
    assign w_s1 = a ^ b;
    assign w_c1 = a & b;
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;
    assign co   = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one result bit per clock through a single full_add.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             w_s, w_co, w_last;

    full_add u_fa (.a(r_a[0]), .b(r_b[0]), .ci(r_c), .s(w_s), .co(w_co));

    assign w_last = r_cnt == CW'(WIDTH - 1);

    // r_res collects bits MSB-side so the final word is ready on the last edge;
    // Sum/Carry only ever see the completed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            Sum     <= '0;
            Carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= A;
                    r_b     <= B;
                    r_c     <= Cin;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    r_state <= ADD;
                end
                ADD: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_co;
                    r_cnt <= r_cnt + CW'(1);
                    r_res <= {w_s, r_res[WIDTH-1:1]};
                    if (w_last) begin
                        Sum     <= {w_s, r_res[WIDTH-1:1]};
                        Carry   <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        Ovf     <= r_c ^ w_co;
`endif
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder against an arithmetic reference.
// Ovf checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, Cin = 1'b0;
    logic [W-1:0] A = '0, B = '0, Sum;
    logic         Carry, busy, done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Ovf;
`endif

    int           checks = 0, failures = 0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_c = 1'b0, exp_o = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
        .Sum(Sum), .Carry(Carry), .busy(busy), .done(done)
`ifdef SERIAL_ADDER_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        exp_sum = t[W-1:0];
        exp_c   = t[W];
        exp_o   = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(Carry), 32'(exp_c));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(Ovf), 32'(exp_o));
`endif
    endtask

    // One operation from IDLE; n counts negedges after the accepting edge,
    // so done at edge k+W is seen at n = W+1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit scramble, input string tag);
        logic [W-1:0] old_sum;
        logic         old_c;
        int           n;
        bit           got;
        old_sum = exp_sum;
        old_c   = exp_c;
        @(negedge clk);
        start = 1'b1; A = a; B = b; Cin = cin;
        @(posedge clk);
        #1 start = 1'b0;
        model(a, b, cin);
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            if (scramble) begin
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            end
            @(negedge clk);
            n++;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) got = 1;
            else begin
                check({tag, "_hold_sum"}, 32'(Sum), 32'(old_sum));
                check({tag, "_hold_carry"}, 32'(Carry), 32'(old_c));
            end
        end
        check({tag, "_done_edge"}, 32'(n - 1), 32'(W));
        check_result(tag);
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done_end"}, 32'(done), 32'd0);
        check_result({tag, "_keep"});
    endtask

    initial begin
        int pulses, last_i;
        bit ok;
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_carry", 32'(Carry), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(Ovf), 32'd0);
`endif
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 0, "wrap1");
        run_op(8'hFF, 8'hFF, 1'b1, 0, "wrap2");
        run_op(8'h7F, 8'h01, 1'b0, 0, "ovf1");
        run_op(8'h80, 8'h80, 1'b0, 0, "ovf2");

        // start held high: accepts at indices 0,10,20,30; done seen at 8,18,28,38
        @(negedge clk);
        start = 1'b1; A = 8'h10; B = 8'h20; Cin = 1'b0;
        model(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        pulses = 0;
        last_i = -2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_period", 32'(i - last_i), (pulses == 0) ? 32'd10 : 32'd10);
                if (pulses == 0) check("b2b_first", 32'(i), 32'd8);
                check_result("b2b");
                pulses++;
                last_i = i;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd4);
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        check("b2b_drain", 32'(ok), 32'd1);

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; A = 8'h5A; B = 8'h3C;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(Sum), 32'd0);
        check("mid_rst_carry", 32'(Carry), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", 32'(Ovf), 32'd0);
`endif
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_nodone", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        exp_sum = '0; exp_c = 1'b0; exp_o = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 0, "post_rst");

        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
